// File: rtl/pdm_audio_dac.sv
// pdm_audio_dac: multi-channel PDM audio DAC with runtime 1st/2nd-order noise shaping, mute and underrun flag.
// Optional macro PDM_DAC_FIFO_EN replaces the one-frame holding register with a FIFO_DEPTH-frame FIFO.
module pdm_audio_dac #(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned WIDTH        = 12,
    parameter int unsigned DIV          = 4,
    parameter int unsigned SAMPLE_TICKS = 32,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [CHANNELS*WIDTH-1:0] sample_data,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic                      mode,
    input  logic                      mute,
    output logic [CHANNELS-1:0]       pdm_o,
    output logic                      sd_o,
    output logic                      underrun
);

    localparam int unsigned FW  = CHANNELS * WIDTH;
    localparam int unsigned DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned FCW = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;
    localparam int unsigned I1W = WIDTH + 2;
    localparam int unsigned I2W = WIDTH + 4;
    localparam int unsigned EW  = WIDTH + 6;

    localparam logic [WIDTH-1:0]     MID      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [EW-1:0] HALF_E   = {{(EW-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [EW-1:0] I1_MAX_E = {{(EW-I1W+1){1'b0}}, {(I1W-1){1'b1}}};
    localparam logic signed [EW-1:0] I1_MIN_E = {{(EW-I1W+1){1'b1}}, {(I1W-1){1'b0}}};
    localparam logic signed [EW-1:0] I2_MAX_E = {{(EW-I2W+1){1'b0}}, {(I2W-1){1'b1}}};
    localparam logic signed [EW-1:0] I2_MIN_E = {{(EW-I2W+1){1'b1}}, {(I2W-1){1'b0}}};

    if (CHANNELS < 1 || WIDTH < 2 || DIV < 1 || SAMPLE_TICKS < 1 || FIFO_DEPTH < 1) begin : g_bad_params
        $error("pdm_audio_dac: illegal parameter set");
    end

    function automatic logic signed [EW-1:0] ext_i1(input logic signed [I1W-1:0] v);
        return {{(EW-I1W){v[I1W-1]}}, v};
    endfunction

    function automatic logic signed [EW-1:0] ext_i2(input logic signed [I2W-1:0] v);
        return {{(EW-I2W){v[I2W-1]}}, v};
    endfunction

    function automatic logic signed [I1W-1:0] sat_i1(input logic signed [EW-1:0] v);
        if (v > I1_MAX_E)      return {1'b0, {(I1W-1){1'b1}}};
        else if (v < I1_MIN_E) return {1'b1, {(I1W-1){1'b0}}};
        else                   return v[I1W-1:0];
    endfunction

    function automatic logic signed [I2W-1:0] sat_i2(input logic signed [EW-1:0] v);
        if (v > I2_MAX_E)      return {1'b0, {(I2W-1){1'b1}}};
        else if (v < I2_MIN_E) return {1'b1, {(I2W-1){1'b0}}};
        else                   return v[I2W-1:0];
    endfunction

    function automatic logic signed [EW-1:0] fb_e(input logic bit_q);
        return bit_q ? HALF_E : -HALF_E;
    endfunction

    logic [DCW-1:0] r_div_cnt;
    logic [FCW-1:0] r_frame_cnt;
    logic           w_tick;
    logic           w_slot;
    logic           w_push;
    logic           w_pop;
    logic           w_empty;
    logic           w_full_n;
    logic [FW-1:0]  w_head;
    logic           r_primed;
    logic [WIDTH-1:0] r_active [CHANNELS];

    assign w_tick = (r_div_cnt == DCW'(DIV - 1));
    assign w_slot = w_tick && (r_frame_cnt == FCW'(SAMPLE_TICKS - 1));
    assign w_push = sample_valid & sample_ready;
    assign w_pop  = w_slot & ~w_empty;

    // Tick divider and frame-slot counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_div_cnt   <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DCW'(1);
            if (w_tick) begin
                r_frame_cnt <= w_slot ? '0 : r_frame_cnt + FCW'(1);
            end
        end
    end

`ifdef PDM_DAC_FIFO_EN
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [FW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] w_wr_ptr_n;
    logic [PW-1:0] w_rd_ptr_n;

    assign w_wr_ptr_n = r_wr_ptr + PW'(w_push);
    assign w_rd_ptr_n = r_rd_ptr + PW'(w_pop);
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full_n   = ((w_wr_ptr_n - w_rd_ptr_n) == PW'(FIFO_DEPTH));
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_n;
            r_rd_ptr <= w_rd_ptr_n;
        end
    end

    // Frame storage carries no reset; emptiness is tracked by the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= sample_data;
        end
    end
`else
    logic [FW-1:0] r_buf;
    logic          r_buf_full;

    assign w_empty  = ~r_buf_full;
    assign w_full_n = w_push | (r_buf_full & ~w_pop);
    assign w_head   = r_buf;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else begin
            r_buf_full <= w_full_n;
            if (w_push) begin
                r_buf <= sample_data;
            end
        end
    end
`endif

    // Handshake, amplifier enable, frame consumption and underrun tracking
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sample_ready <= 1'b0;
            sd_o         <= 1'b0;
            underrun     <= 1'b0;
            r_primed     <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_active[c] <= MID;
            end
        end else begin
            sample_ready <= ~w_full_n;
            sd_o         <= 1'b1;
            if (w_slot) begin
                if (!w_empty) begin
                    r_primed <= 1'b1;
                    for (int c = 0; c < CHANNELS; c++) begin
                        r_active[c] <= w_head[c*WIDTH +: WIDTH];
                    end
                end else if (r_primed) begin
                    underrun <= 1'b1;
                end
            end
        end
    end

    logic                   r_mode_q;
    logic [CHANNELS-1:0]    r_pdm;
    logic [WIDTH-1:0]       r_acc  [CHANNELS];
    logic signed [I1W-1:0]  r_i1   [CHANNELS];
    logic signed [I2W-1:0]  r_i2   [CHANNELS];
    logic [WIDTH-1:0]       w_x    [CHANNELS];
    logic [WIDTH:0]         w_s1   [CHANNELS];
    logic signed [I1W-1:0]  w_i1_n [CHANNELS];
    logic signed [I2W-1:0]  w_i2_n [CHANNELS];

    // Next-state of both modulator orders per channel; the active order is chosen at the register
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_x[c]    = mute ? MID : r_active[c];
            w_s1[c]   = {1'b0, r_acc[c]} + {1'b0, w_x[c]};
            w_i1_n[c] = sat_i1(ext_i1(r_i1[c]) + $signed({{(EW-WIDTH){1'b0}}, w_x[c]})
                               - HALF_E - fb_e(r_pdm[c]));
            w_i2_n[c] = sat_i2(ext_i2(r_i2[c]) + ext_i1(w_i1_n[c]) - fb_e(r_pdm[c]));
        end
    end

    // Modulator state; an order change wipes state so nothing leaks between orders
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_mode_q <= 1'b0;
            r_pdm    <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_acc[c] <= '0;
                r_i1[c]  <= '0;
                r_i2[c]  <= '0;
            end
        end else if (w_tick) begin
            r_mode_q <= mode;
            for (int c = 0; c < CHANNELS; c++) begin
                if (mode != r_mode_q) begin
                    r_acc[c] <= '0;
                    r_i1[c]  <= '0;
                    r_i2[c]  <= '0;
                    r_pdm[c] <= 1'b0;
                end else if (!r_mode_q) begin
                    r_acc[c] <= w_s1[c][WIDTH-1:0];
                    r_pdm[c] <= w_s1[c][WIDTH];
                end else begin
                    r_i1[c]  <= w_i1_n[c];
                    r_i2[c]  <= w_i2_n[c];
                    r_pdm[c] <= ~w_i2_n[c][I2W-1];
                end
            end
        end
    end

    assign pdm_o = r_pdm;

endmodule

// File: tb/tb_pdm_audio_dac.sv
// Bench for pdm_audio_dac: cycle reference model built from the behavioural rules, plus density,
// handshake, underrun and reset checks.
`timescale 1ns/1ps
module tb_pdm_audio_dac;

    localparam int CH   = 2;
    localparam int W    = 12;
    localparam int DIV  = 3;
    localparam int ST   = 8;
    localparam int FD   = 4;
    localparam int FW   = CH * W;
    localparam int HALF = 1 << (W - 1);
    localparam int FULL = 1 << W;
`ifdef PDM_DAC_FIFO_EN
    localparam int CAP = FD;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic [FW-1:0] sample_data;
    logic          sample_valid;
    logic          sample_ready;
    logic          mode;
    logic          mute;
    logic [CH-1:0] pdm_o;
    logic          sd_o;
    logic          underrun;

    always #5 clk = ~clk;

    pdm_audio_dac #(
        .CHANNELS(CH), .WIDTH(W), .DIV(DIV), .SAMPLE_TICKS(ST), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rstn(rstn), .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .mode(mode), .mute(mute), .pdm_o(pdm_o),
        .sd_o(sd_o), .underrun(underrun)
    );

    // Reference model state
    int            m_div, m_frame;
    int            m_active [CH];
    int            m_acc [CH];
    int            m_i1 [CH];
    int            m_i2 [CH];
    bit [CH-1:0]   m_pdm;
    bit            m_mode_q, m_primed, m_under, m_ready, m_sd;
    bit            m_tick, m_slot, m_pop, m_push;
    logic [FW-1:0] m_q [$];

    int n_cmp = 0;
    int n_bad = 0;
    int ones [CH];
    int ticks;
    int accepts;
    bit last_acc;

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic logic [FW-1:0] mk(input int a, input int b);
        logic [W-1:0] la, lb;
        la = W'(a);
        lb = W'(b);
        return {lb, la};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert ((obs >= lo && obs <= hi) === 1'b1) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Advances the model by one clock edge using the inputs currently driven
    task automatic model_step();
        logic [FW-1:0] f;
        int x, s;
        m_tick = 0; m_slot = 0; m_pop = 0; m_push = 0;
        if (!rstn) begin
            m_div = 0; m_frame = 0; m_q.delete();
            m_pdm = '0; m_mode_q = 0; m_primed = 0; m_under = 0; m_ready = 0; m_sd = 0;
            for (int c = 0; c < CH; c++) begin
                m_active[c] = HALF; m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0;
            end
        end else begin
            m_push = sample_valid && m_ready;
            m_tick = (m_div == DIV - 1);
            m_div  = m_tick ? 0 : m_div + 1;
            if (m_tick) begin
                m_slot  = (m_frame == ST - 1);
                m_frame = (m_frame + 1) % ST;
                if (mode != m_mode_q) begin
                    m_mode_q = mode;
                    m_pdm = '0;
                    for (int c = 0; c < CH; c++) begin
                        m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0;
                    end
                end else begin
                    for (int c = 0; c < CH; c++) begin
                        x = mute ? HALF : m_active[c];
                        if (!m_mode_q) begin
                            s = (m_acc[c] % FULL) + x;
                            m_pdm[c] = (s >= FULL);
                            m_acc[c] = s % FULL;
                        end else begin
                            m_i1[c] = clamp(m_i1[c] + (x - HALF) - (m_pdm[c] ? HALF : -HALF),
                                            -4 * HALF, 4 * HALF - 1);
                            m_i2[c] = clamp(m_i2[c] + m_i1[c] - (m_pdm[c] ? HALF : -HALF),
                                            -16 * HALF, 16 * HALF - 1);
                            m_pdm[c] = (m_i2[c] >= 0);
                        end
                    end
                end
            end
            if (m_slot) begin
                if (m_q.size() > 0) begin
                    f = m_q.pop_front();
                    for (int c = 0; c < CH; c++) m_active[c] = int'(f[c*W +: W]);
                    m_primed = 1; m_pop = 1;
                end else if (m_primed) begin
                    m_under = 1;
                end
            end
            if (m_push) m_q.push_back(sample_data);
            m_ready = (m_q.size() < CAP);
            m_sd = 1;
        end
    endtask

    // One clock: model step, edge, then compare every output against the model
    task automatic cyc();
        bit acc_now;
        acc_now = sample_valid && sample_ready;
        model_step();
        @(posedge clk);
        #1;
        last_acc = acc_now;
        if (acc_now) accepts++;
        chk("pdm_o", 32'(pdm_o), 32'(m_pdm));
        chk("sample_ready", 32'(sample_ready), 32'(m_ready));
        chk("sd_o", 32'(sd_o), 32'(m_sd));
        chk("underrun", 32'(underrun), 32'(m_under));
        if (m_tick) begin
            ticks++;
            for (int c = 0; c < CH; c++) ones[c] += int'(pdm_o[c]);
        end
    endtask

    task automatic do_reset(input int n);
        rstn = 0; sample_valid = 0;
        repeat (n) cyc();
        rstn = 1;
    endtask

    task automatic send(input logic [FW-1:0] f);
        sample_data = f; sample_valid = 1; last_acc = 0;
        for (int i = 0; i < 2 * DIV * ST + 4; i++) begin
            cyc();
            if (last_acc) break;
        end
        if (!last_acc) chk("send_timeout", 0, 1);
        sample_valid = 0;
    endtask

    task automatic wait_slot(input bit need_pop);
        bit hit;
        hit = 0;
        for (int i = 0; i < 2 * DIV * ST + 4; i++) begin
            cyc();
            if (m_slot && (!need_pop || m_pop)) begin hit = 1; break; end
        end
        if (!hit) chk("slot_timeout", 0, 1);
    endtask

    task automatic run_ticks(input int n);
        ticks = 0;
        for (int c = 0; c < CH; c++) ones[c] = 0;
        for (int i = 0; i < n * DIV + 8; i++) begin
            if (ticks == n) break;
            cyc();
        end
        if (ticks != n) chk("tick_timeout", 32'(ticks), 32'(n));
    endtask

    initial begin
        int slots;
        rstn = 0; sample_valid = 0; sample_data = '0; mode = 0; mute = 0;
        accepts = 0; ticks = 0; last_acc = 0;
        for (int c = 0; c < CH; c++) ones[c] = 0;

        // Reset state and first cycle after release
        do_reset(2);
        chk("rst_pdm", 32'(pdm_o), 0);
        chk("rst_ready", 32'(sample_ready), 0);
        chk("rst_sd", 32'(sd_o), 0);
        cyc();
        chk("rel_ready", 32'(sample_ready), 1);
        chk("rel_sd", 32'(sd_o), 1);

        // 1st order, quarter scale: one pulse every 4th tick
        send(mk('h400, $urandom_range(0, FULL - 1)));
        wait_slot(1);
        run_ticks(64);
        chk("quarter_ones", 32'(ones[0]), 16);

        // 1st order extremes
        send(mk('h000, 'h000));
        wait_slot(1);
        run_ticks(64);
        chk("zero_ones_ch0", 32'(ones[0]), 0);
        chk("zero_ones_ch1", 32'(ones[1]), 0);
        send(mk('hFFF, 'hFFF));
        wait_slot(1);
        run_ticks(4096);
        chk("full_ones_ch0", 32'(ones[0]), 4095);
        chk("full_ones_ch1", 32'(ones[1]), 4095);

        // 2nd order densities
        mode = 1;
        send(mk('h800, 'h800));
        wait_slot(1);
        run_ticks(1024);
        chk_rng("o2_mid_ch0", ones[0], 510, 514);
        send(mk('hC00, 'hC00));
        wait_slot(1);
        run_ticks(1024);
        chk_rng("o2_3q_ch0", ones[0], 764, 772);
        chk_rng("o2_3q_ch1", ones[1], 764, 772);

        // Mute forces midscale into the 1st-order modulator
        mode = 0; mute = 1;
        run_ticks(4);
        run_ticks(64);
        chk("mute_ones", 32'(ones[0]), 32);
        mute = 0;

        // Underrun: none before first frame, set at second slot, sticky
        do_reset(1);
        wait_slot(0);
        chk("no_underrun_unprimed", 32'(underrun), 0);
        send(mk($urandom_range(0, FULL - 1), $urandom_range(0, FULL - 1)));
        wait_slot(1);
        chk("no_underrun_first", 32'(underrun), 0);
        wait_slot(0);
        chk("underrun_set", 32'(underrun), 1);
        repeat (20) cyc();
        chk("underrun_sticky", 32'(underrun), 1);

        // Reset mid-frame with a buffered frame
        send(mk($urandom_range(0, FULL - 1), $urandom_range(0, FULL - 1)));
        repeat (3) cyc();
        rstn = 0;
        cyc();
        chk("midrst_pdm", 32'(pdm_o), 0);
        chk("midrst_sd", 32'(sd_o), 0);
        chk("midrst_ready", 32'(sample_ready), 0);
        chk("midrst_underrun", 32'(underrun), 0);
        rstn = 1;
        cyc();
        chk("midrst_rel_ready", 32'(sample_ready), 1);
        chk("midrst_rel_sd", 32'(sd_o), 1);

        // Back-pressure: valid held high, one accept per slot once full
        do_reset(1);
        accepts = 0; slots = 0;
        sample_data = FW'($urandom); sample_valid = 1;
        for (int i = 0; i < 4 * DIV * ST; i++) begin
            cyc();
            if (last_acc) sample_data = FW'($urandom);
            if (m_slot) slots++;
            if (slots == 3) break;
        end
        repeat (2) begin
            cyc();
            if (last_acc) sample_data = FW'($urandom);
        end
        chk("accept_count", 32'(accepts), 32'(CAP + 3));
        sample_valid = 0;

        // Randomised traffic, mode toggles and mute against the model
        for (int i = 0; i < 4000; i++) begin
            sample_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0: sample_data = mk(0, FULL - 1);
                1: sample_data = mk(FULL - 1, 0);
                default: sample_data = FW'($urandom);
            endcase
            if ($urandom_range(0, 299) == 0) mode = ~mode;
            if ($urandom_range(0, 149) == 0) mute = ~mute;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
